// File: rtl/ntt_bridge_arbiter.sv
// ntt_bridge_arbiter
//   Round-robin arbiter that merges N_REQ coefficient streams onto the single
//   bus-side write port of the NTT bridge. A grant covers one burst, which ends
//   on req_last, after BURST_LEN beats, or after TIMEOUT idle cycles (abort).
//   The data path from the granted requester to the output is combinational.
//
// Ports
//   clk_bus      in   sole clock, posedge
//   rst          in   synchronous active-high reset
//   req_valid    in   [N_REQ]        per-requester word valid
//   req_data     in   [N_REQ*WIDTH]  packed words, requester i at [i*WIDTH +: WIDTH]
//   req_last     in   [N_REQ]        final word of a requester's burst
//   req_ready    out  [N_REQ]        per-requester accept
//   out_valid    out  word valid toward the bridge
//   out_data     out  [WIDTH] forwarded word
//   out_src      out  [SRC_W] index of the granted requester
//   out_ready    in   bridge not full
//   busy         out  high while a burst is open
//   abort_pulse  out  one-cycle pulse when a burst times out
module ntt_bridge_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 32
) (
  input  logic                     clk_bus,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_src,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     abort_pulse
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic               abort_q, abort_d;

  logic               found;
  logic [SRC_W-1:0]   sel;
  int                 scan_idx;
  logic               cur_valid;
  logic               cur_last;
  logic               beat;
  logic               in_burst;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(last_grant_q) + k) % N_REQ;
      if (!found && req_valid[SRC_W'(scan_idx)]) begin
        found = 1'b1;
        sel   = SRC_W'(scan_idx);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    abort_d      = 1'b0;
    cur_valid    = req_valid[grant_q];
    cur_last     = req_last[grant_q];
    beat         = (state_q == BURST) && cur_valid && out_ready;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BURST;
          grant_d      = sel;
          last_grant_d = sel;
          beat_cnt_d   = '0;
          idle_cnt_d   = '0;
        end
      end
      BURST: begin
        if (beat) begin
          idle_cnt_d = '0;
          // req_last and the length limit share one exit path.
          if (cur_last || (beat_cnt_q == CNT_W'(BURST_LEN - 1))) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (cur_valid) begin
          // Backpressure is not idleness.
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
          beat_cnt_d = '0;
          abort_d    = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(N_REQ - 1);
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      abort_q      <= abort_d;
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge.
  always_comb begin
    in_burst    = (state_q == BURST) && !rst;
    busy        = in_burst;
    out_valid   = in_burst && req_valid[grant_q];
    out_data    = in_burst ? req_data[int'(grant_q)*WIDTH +: WIDTH] : '0;
    out_src     = in_burst ? grant_q : '0;
    req_ready   = '0;
    if (in_burst) req_ready[grant_q] = out_ready;
    abort_pulse = abort_q && !rst;
  end

endmodule

// File: tb/tb_ntt_bridge_arbiter.sv
module tb_ntt_bridge_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BL = 8;
  localparam int TO = 32;

  logic             clk_bus = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_src;
  logic             out_ready;
  logic             busy;
  logic             abort_pulse;

  ntt_bridge_arbiter #(.N_REQ(N), .WIDTH(W), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_bus(clk_bus), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .busy(busy), .abort_pulse(abort_pulse)
  );

  always #5 clk_bus = ~clk_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int widx[N];
  int exp_seq[N];

  logic         o_valid, o_busy, o_abort;
  logic [W-1:0] o_data;
  logic [1:0]   o_src;
  logic [N-1:0] o_ready;

  function automatic logic [W-1:0] word(input int r, input int s);
    return {4'(r), 12'(s)};
  endfunction

  // One clock: present each requester's current word, sample outputs mid-cycle,
  // then advance the requester model on the handshakes seen.
  task automatic tick();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word(i, widx[i]);
    #2;
    o_valid = out_valid; o_data = out_data; o_src = out_src;
    o_ready = req_ready; o_busy = busy;     o_abort = abort_pulse;
    @(posedge clk_bus); #1;
    for (int i = 0; i < N; i++) if (req_valid[i] && o_ready[i]) widx[i]++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_last = '0; out_ready = 1'b1;
    tick();
    n_checks++; if ({o_valid, o_busy, o_abort} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b required 000", {o_valid, o_busy, o_abort}); end
    n_checks++; if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b required 0000", o_ready); end
    n_checks++; if ({o_src, o_data} !== '0) begin n_fail++; $display("FAIL reset_data: got src %0d data %h required 0", o_src, o_data); end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_round_robin();
    req_valid = 4'b1111; out_ready = 1'b1; req_last = '0;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_checks++; if ({o_busy, o_valid} !== 2'b00) begin n_fail++; $display("FAIL rr_gap%0d: got busy/valid %b required 00", g, {o_busy, o_valid}); end
      for (int b = 0; b < BL; b++) begin
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_src !== 2'(g % N) || o_data !== word(g % N, exp_seq[g % N])) begin
          n_fail++; $display("FAIL rr_beat g%0d b%0d: got v%b src %0d data %h required v1 src %0d data %h",
                             g, b, o_valid, o_src, o_data, g % N, word(g % N, exp_seq[g % N]));
        end
        exp_seq[g % N]++;
      end
    end
    req_valid = '0;
    tick();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_busy: got %b required 0", o_busy); end
  endtask

  task automatic test_last();
    req_valid = 4'b0100; req_last = '0; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      req_last = (b == 2) ? 4'b0100 : 4'b0000;
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_src !== 2'd2 || o_data !== word(2, exp_seq[2])) begin
        n_fail++; $display("FAIL last_beat%0d: got v%b src %0d data %h required v1 src 2 data %h", b, o_valid, o_src, o_data, word(2, exp_seq[2]));
      end
      exp_seq[2]++;
    end
    req_valid = '0; req_last = '0;
    tick();
    n_checks++; if ({o_busy, o_valid} !== 2'b00) begin n_fail++; $display("FAIL last_exit: got busy/valid %b required 00", {o_busy, o_valid}); end
  endtask

  task automatic test_backpressure();
    int aborts;
    aborts = 0;
    req_valid = 4'b0010; req_last = '0; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      tick();
      n_checks++; if (o_src !== 2'd1 || o_data !== word(1, exp_seq[1])) begin n_fail++; $display("FAIL bp_pre%0d: got src %0d data %h required src 1 data %h", b, o_src, o_data, word(1, exp_seq[1])); end
      exp_seq[1]++;
    end
    out_ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (o_abort) aborts++;
      if (o_valid !== 1'b1 || o_ready !== 4'b0000 || o_data !== word(1, exp_seq[1])) begin
        n_checks++; n_fail++;
        $display("FAIL bp_hold c%0d: got v%b ready %b data %h required v1 ready 0000 data %h", c, o_valid, o_ready, o_data, word(1, exp_seq[1]));
      end
    end
    n_checks++;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick();
      if (o_abort) aborts++;
      n_checks++; if (o_valid !== 1'b1 || o_data !== word(1, exp_seq[1])) begin n_fail++; $display("FAIL bp_post%0d: got v%b data %h required v1 data %h", b, o_valid, o_data, word(1, exp_seq[1])); end
      exp_seq[1]++;
    end
    req_valid = '0;
    tick();
    if (o_abort) aborts++;
    n_checks++; if (aborts !== 0) begin n_fail++; $display("FAIL bp_abort: got %0d abort pulses required 0", aborts); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_exit: got busy %b required 0", o_busy); end
  endtask

  task automatic test_timeout();
    req_valid = 4'b1000; req_last = '0; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      tick();
      n_checks++; if (o_src !== 2'd3 || o_data !== word(3, exp_seq[3])) begin n_fail++; $display("FAIL to_beat%0d: got src %0d data %h required src 3 data %h", b, o_src, o_data, word(3, exp_seq[3])); end
      exp_seq[3]++;
    end
    req_valid = '0;
    for (int j = 0; j < 32; j++) begin
      tick();
      if (o_abort !== 1'b0 || o_busy !== 1'b1) begin
        n_checks++; n_fail++; $display("FAIL to_wait j%0d: got abort %b busy %b required abort 0 busy 1", j, o_abort, o_busy);
      end
    end
    n_checks++;
    req_valid = 4'b0111;
    tick();
    n_checks++; if ({o_abort, o_busy} !== 2'b10) begin n_fail++; $display("FAIL to_pulse: got abort/busy %b required 10", {o_abort, o_busy}); end
    req_last = 4'b0001;
    tick();
    n_checks++; if (o_abort !== 1'b0 || o_src !== 2'd0 || o_data !== word(0, exp_seq[0])) begin n_fail++; $display("FAIL to_regrant: got abort %b src %0d data %h required abort 0 src 0 data %h", o_abort, o_src, o_data, word(0, exp_seq[0])); end
    exp_seq[0]++;
    req_valid = '0; req_last = '0;
    tick();
    n_checks++; if ({o_busy, o_abort} !== 2'b00) begin n_fail++; $display("FAIL to_exit: got busy/abort %b required 00", {o_busy, o_abort}); end
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 4'b0110; req_last = '0; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      tick();
      n_checks++; if (o_src !== 2'd1 || o_data !== word(1, exp_seq[1])) begin n_fail++; $display("FAIL rm_beat%0d: got src %0d data %h required src 1 data %h", b, o_src, o_data, word(1, exp_seq[1])); end
      exp_seq[1]++;
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({o_valid, o_busy, o_abort} !== 3'b000 || o_ready !== 4'b0000 || o_src !== 2'd0 || o_data !== 16'h0) begin
        n_fail++; $display("FAIL rm_zero c%0d: got v%b busy%b abort%b ready %b src %0d data %h required all 0", c, o_valid, o_busy, o_abort, o_ready, o_src, o_data);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++; if ({o_busy, o_abort} !== 2'b00) begin n_fail++; $display("FAIL rm_release: got busy/abort %b required 00", {o_busy, o_abort}); end
    req_last = 4'b0010;
    tick();
    n_checks++; if (o_src !== 2'd1 || o_valid !== 1'b1 || o_data !== word(1, exp_seq[1])) begin n_fail++; $display("FAIL rm_first: got v%b src %0d data %h required v1 src 1 data %h", o_valid, o_src, o_data, word(1, exp_seq[1])); end
    exp_seq[1]++;
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_random();
    int waitb[N];
    logic prev_busy;
    logic [N-1:0] cur_v, prev_v, exp_rdy;
    int errs;
    prev_busy = 1'b0; prev_v = '0; errs = 0;
    for (int i = 0; i < N; i++) waitb[i] = 0;
    req_valid = '0; req_last = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_last[i]  = ($urandom_range(0, 3) == 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cur_v = req_valid;
      tick();
      exp_rdy = '0;
      if (o_busy) exp_rdy[o_src] = out_ready;
      n_checks++; if (o_ready !== exp_rdy) begin n_fail++; if (errs++ < 10) $display("FAIL rnd_ready c%0d: got %b required %b", c, o_ready, exp_rdy); end
      if (o_valid && out_ready) begin
        n_checks++;
        if (o_data !== word(int'(o_src), exp_seq[o_src])) begin
          n_fail++; if (errs++ < 10) $display("FAIL rnd_data c%0d: got %h required %h", c, o_data, word(int'(o_src), exp_seq[o_src]));
        end
        exp_seq[o_src]++;
      end
      if (o_busy && !prev_busy) begin
        n_checks++;
        for (int i = 0; i < N; i++) begin
          if (i == int'(o_src) || !prev_v[i]) waitb[i] = 0;
          else waitb[i]++;
        end
        if (waitb[0] > N-1 || waitb[1] > N-1 || waitb[2] > N-1 || waitb[3] > N-1) begin
          n_fail++; if (errs++ < 10) $display("FAIL rnd_starve c%0d: got waits %0d %0d %0d %0d required <= %0d", c, waitb[0], waitb[1], waitb[2], waitb[3], N-1);
        end
      end
      prev_busy = o_busy;
      prev_v    = cur_v;
      for (int i = 0; i < N; i++) if (req_valid[i] && o_ready[i]) req_valid[i] = 1'b0;
    end
    req_valid = '0; req_last = '0;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      n_checks++; if (widx[i] !== exp_seq[i]) begin n_fail++; $display("FAIL rnd_count r%0d: got %0d beats required %0d handshakes", i, exp_seq[i], widx[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin widx[i] = 0; exp_seq[i] = 0; end
    repeat (3) @(posedge clk_bus);
    #1;
    test_reset();
    test_round_robin();
    test_last();
    test_backpressure();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
